// File: rtl/awgn_coeff_pkg.sv
// Shared constants and loader state encoding for the AWGN coefficient memory.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package awgn_coeff_pkg;

    localparam int COEFF_W     = 52;   // coefficient word width
    localparam int COEFF_AW    = 7;    // coefficient memory address width
    localparam int COEFF_DEPTH = 128;  // words per full table
    localparam int COEFF_BPW   = 7;    // stream bytes per word (56 bits, top 4 unused)

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_WRITE   = 2'd2
    } ld_state_t;

endpackage

// File: rtl/coeff_byte_packer.sv
// Packs stream bytes little-endian into one BPW-byte word; word_ready marks the last byte.
// Latency: word valid on the cycle after the BPW-th accepted byte.
// Backpressure: none internally; the caller gates byte_en with its own ready.
//
// Ports:
//   clk, rst     clock, async active-high reset
//   clear        zero the byte counter and pack register (priority over byte_en)
//   byte_en      a byte is accepted this cycle
//   data         the accepted byte
//   word_ready   this cycle's accepted byte completes the word
//   word         pack register; first byte of a word ends up in bits [7:0]
module coeff_byte_packer
    import awgn_coeff_pkg::*;
#(
    parameter int BPW = COEFF_BPW
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 byte_en,
    input  logic [7:0]           data,
    output logic                 word_ready,
    output logic [8*BPW-1:0]     word
);

    localparam int PACK_W = 8 * BPW;
    localparam int CNT_W  = (BPW > 1) ? $clog2(BPW) : 1;

    logic [CNT_W-1:0]  byte_cnt;
    logic [PACK_W-1:0] pack;
    logic              last_byte;

    assign last_byte  = (byte_cnt == CNT_W'(BPW - 1));
    assign word_ready = byte_en && last_byte;
    assign word       = pack;

    // Bytes shift in from the top, so after BPW bytes the first one sits at [7:0].
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byte_cnt <= '0;
            pack     <= '0;
        end else if (clear) begin
            byte_cnt <= '0;
            pack     <= '0;
        end else if (byte_en) begin
            pack     <= {data, pack[PACK_W-1:8]};
            byte_cnt <= last_byte ? '0 : byte_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/coeff_mem_loader.sv
// Loads the full coefficient table from a byte stream; otherwise serves datapath reads.
// Latency: read data 1 cycle after rd_req&&rd_ready; one write per 7 accepted bytes + 1 cycle.
// Backpressure: s_ready low outside COLLECT (incl. the WRITE cycle); rd_ready low while loading.
//
// Ports:
//   clk, rst                      clock, async active-high reset
//   load_start                    request a full-table load (honoured only in IDLE)
//   s_data/s_valid/s_ready        coefficient byte stream
//   rd_req/rd_addr/rd_ready       datapath read request
//   rd_valid/rd_data              read response; rd_data holds between responses
//   mem_we/mem_addr/mem_wdata     memory port (wdata floats when not writing)
//   mem_rdata                     memory read data, 1-cycle registered in the memory
//   load_busy/load_done           load in progress / one-cycle completion pulse
//   table_loaded/fmt_err          sticky status, cleared by rst or an accepted load_start
module coeff_mem_loader
    import awgn_coeff_pkg::*;
#(
    parameter int DATA_WIDTH     = COEFF_W,
    parameter int ADDR_WIDTH     = COEFF_AW,
    parameter int DEPTH          = COEFF_DEPTH,
    parameter int BYTES_PER_WORD = COEFF_BPW
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_start,
    input  logic [7:0]            s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic                  rd_req,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  rd_ready,
    output logic                  rd_valid,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  load_busy,
    output logic                  load_done,
    output logic                  table_loaded,
    output logic                  fmt_err
);

    localparam int PACK_W = 8 * BYTES_PER_WORD;

    ld_state_t             state;
    logic [ADDR_WIDTH-1:0] word_cnt;
    logic [DATA_WIDTH-1:0] rd_hold;

    logic                  accept;
    logic                  rd_issue;
    logic                  pk_clear;
    logic                  word_ready;
    logic [PACK_W-1:0]     word;
    logic                  last_word;
    logic                  bad_pad;

    assign s_ready   = (state == ST_COLLECT);
    assign rd_ready  = (state == ST_IDLE);
    assign load_busy = (state != ST_IDLE);
    assign mem_we    = (state == ST_WRITE);

    assign accept    = s_valid && s_ready;
    assign rd_issue  = rd_req && rd_ready;
    assign last_word = (word_cnt == ADDR_WIDTH'(DEPTH - 1));
    assign bad_pad   = |word[PACK_W-1:DATA_WIDTH];

    // Packer restarts at the beginning of a load and right after each word is written.
    assign pk_clear  = ((state == ST_IDLE) && load_start) || (state == ST_WRITE);

    coeff_byte_packer #(
        .BPW (BYTES_PER_WORD)
    ) u_packer (
        .clk        (clk),
        .rst        (rst),
        .clear      (pk_clear),
        .byte_en    (accept),
        .data       (s_data),
        .word_ready (word_ready),
        .word       (word)
    );

    // Single memory port: datapath address in IDLE, the word counter while loading.
    always_comb begin
        mem_addr = '0;
        if (state == ST_IDLE) begin
            if (rd_req) begin
                mem_addr = rd_addr;
            end
        end else begin
            mem_addr = word_cnt;
        end
    end

    assign mem_wdata = mem_we ? word[DATA_WIDTH-1:0] : {DATA_WIDTH{1'bz}};

    // The memory registers its output, so the response cycle passes rdata straight
    // through; the hold register keeps it visible until the next response.
    assign rd_data = rd_valid ? mem_rdata : rd_hold;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            word_cnt     <= '0;
            rd_valid     <= 1'b0;
            rd_hold      <= '0;
            load_done    <= 1'b0;
            table_loaded <= 1'b0;
            fmt_err      <= 1'b0;
        end else begin
            load_done <= 1'b0;
            rd_valid  <= rd_issue;
            if (rd_valid) begin
                rd_hold <= mem_rdata;
            end

            case (state)
                ST_IDLE: begin
                    if (load_start) begin
                        table_loaded <= 1'b0;
                        fmt_err      <= 1'b0;
                        word_cnt     <= '0;
                        state        <= ST_COLLECT;
                    end
                end
                ST_COLLECT: begin
                    if (word_ready) begin
                        state <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    if (bad_pad) begin
                        fmt_err <= 1'b1;
                    end
                    // Counter stops at the last word rather than wrapping.
                    if (last_word) begin
                        load_done    <= 1'b1;
                        table_loaded <= 1'b1;
                        state        <= ST_IDLE;
                    end else begin
                        word_cnt <= word_cnt + 1'b1;
                        state    <= ST_COLLECT;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
